// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the keypad emulator: key codes, matrix map, FSM states.
package keypad_emulator_pkg;

    localparam int unsigned KEY_W         = 4;
    localparam int unsigned STROBE_W      = 4;
    localparam int unsigned BOUNCE_CYCLES = 8;

    localparam logic [KEY_W-1:0] KEY_0 = 4'h0;
    localparam logic [KEY_W-1:0] KEY_1 = 4'h1;
    localparam logic [KEY_W-1:0] KEY_2 = 4'h2;
    localparam logic [KEY_W-1:0] KEY_3 = 4'h3;
    localparam logic [KEY_W-1:0] KEY_4 = 4'h4;
    localparam logic [KEY_W-1:0] KEY_5 = 4'h5;
    localparam logic [KEY_W-1:0] KEY_6 = 4'h6;
    localparam logic [KEY_W-1:0] KEY_7 = 4'h7;
    localparam logic [KEY_W-1:0] KEY_8 = 4'h8;
    localparam logic [KEY_W-1:0] KEY_9 = 4'h9;
    localparam logic [KEY_W-1:0] KEY_A = 4'hA;
    localparam logic [KEY_W-1:0] KEY_B = 4'hB;
    localparam logic [KEY_W-1:0] KEY_C = 4'hC;
    localparam logic [KEY_W-1:0] KEY_D = 4'hD;
    localparam logic [KEY_W-1:0] KEY_E = 4'hE;
    localparam logic [KEY_W-1:0] KEY_F = 4'hF;

    // Active-low row/column patterns indexed by key code; entries listed from KEY_F down to KEY_0.
    localparam logic [15:0][STROBE_W-1:0] ROW_N_MAP = {
        4'b0111, 4'b0111, 4'b0111, 4'b0111,   // F E D C
        4'b1011, 4'b1101, 4'b1011, 4'b1101,   // B A 9 8
        4'b1110, 4'b1011, 4'b1101, 4'b1110,   // 7 6 5 4
        4'b1011, 4'b1101, 4'b1110, 4'b1110    // 3 2 1 0
    };

    localparam logic [15:0][STROBE_W-1:0] COL_N_MAP = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110,   // F E D C
        4'b0111, 4'b0111, 4'b1110, 4'b1110,   // B A 9 8
        4'b1110, 4'b1101, 4'b1101, 4'b1101,   // 7 6 5 4
        4'b1011, 4'b1011, 4'b1011, 4'b0111    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_GAP    = 2'd2,
        ST_BOUNCE = 2'd3
    } emu_state_t;

endpackage

// File: rtl/keypad_emu_fifo.sv
// Synchronous key-code FIFO with full/empty flags; depth must be a power of two.
module keypad_emu_fifo
    import keypad_emulator_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = KEY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad responder: queued keys are held closed, then released, and answer row strobes.
// Define KEYPAD_EMU_BOUNCE_EN to insert an 8-cycle contact-bounce phase before each press.
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 64,
    parameter int unsigned GAP_CYCLES  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [STROBE_W-1:0] row_n,
    output logic [STROBE_W-1:0] col_n,
    output logic                pressing,
    output logic                busy,
    output logic                done
);

    emu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] r_held_key;
    logic             r_pressing;
    logic             r_done;

    logic [KEY_W-1:0] w_fifo_data;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_row_hit;

    assign w_push = key_valid && !w_full;
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;

    keypad_emu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (key_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_held_key <= '0;
            r_pressing <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_held_key <= w_fifo_data;
                        r_cnt      <= '0;
                        r_pressing <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        r_state    <= ST_BOUNCE;
`else
                        r_state    <= ST_PRESS;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                // Contact closed on even bounce counts: next count is even when this one is odd.
                ST_BOUNCE: begin
                    if (r_cnt == CNT_W'(BOUNCE_CYCLES - 1)) begin
                        r_cnt      <= '0;
                        r_pressing <= 1'b1;
                        r_state    <= ST_PRESS;
                    end else begin
                        r_cnt      <= r_cnt + CNT_W'(1);
                        r_pressing <= r_cnt[0];
                    end
                end
`endif
                ST_PRESS: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_cnt      <= '0;
                        r_pressing <= 1'b0;
                        r_state    <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt      <= '0;
                    r_pressing <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency switch model: any low strobe on the held key's row pulls its column low.
    assign w_row_hit = r_pressing && ((~row_n & ~ROW_N_MAP[r_held_key]) != '0);
    assign col_n     = w_row_hit ? COL_N_MAP[r_held_key] : '1;

    assign key_ready = !w_full;
    assign busy      = !w_empty || (r_state != ST_IDLE);
    assign pressing  = r_pressing;
    assign done      = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator (default build and KEYPAD_EMU_BOUNCE_EN build).
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       pressing;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES (64),
        .GAP_CYCLES  (32),
        .FIFO_DEPTH  (4),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .row_n     (row_n),
        .col_n     (col_n),
        .pressing  (pressing),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [3:0] row_of(input logic [3:0] k);
        case (k)
            4'hF, 4'hE, 4'hD, 4'hC: row_of = 4'b0111;
            4'hB, 4'h3, 4'h6, 4'h9: row_of = 4'b1011;
            4'hA, 4'h2, 4'h5, 4'h8: row_of = 4'b1101;
            default:                row_of = 4'b1110;
        endcase
    endfunction

    function automatic logic [3:0] col_of(input logic [3:0] k);
        case (k)
            4'hF, 4'hB, 4'hA, 4'h0: col_of = 4'b0111;
            4'hE, 4'h3, 4'h2, 4'h1: col_of = 4'b1011;
            4'hD, 4'h6, 4'h5, 4'h4: col_of = 4'b1101;
            default:                col_of = 4'b1110;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting clock edge.
    task automatic push(input logic [3:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 400) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if (col_n !== 4'b1111 || pressing !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: col_n=%b pressing=%b done=%b busy=%b, required 1111/0/0/0",
                     col_n, pressing, done, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: key_ready=%b busy=%b, required 1/0", key_ready, busy);
        end
    endtask

    task automatic test_single_key();
        int n_done;
        n_done = 0;
        push(4'h5);
        n_tests++;
        if (pressing !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: pressing=%b busy=%b, required 0/1", pressing, busy);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_tests++;
            if (pressing !== (c < 64)) begin
                n_fail++;
                $display("FAIL single_pressing c=%0d: got %b, required %b", c, pressing, (c < 64));
            end
            n_tests++;
            if (done !== (c == 96)) begin
                n_fail++;
                $display("FAIL single_done c=%0d: got %b, required %b", c, done, (c == 96));
            end
            if (done) n_done++;
            if (c < 96) begin
                row_n = 4'b1101;
                #1;
                n_tests++;
                if (col_n !== ((c < 64) ? 4'b1101 : 4'b1111)) begin
                    n_fail++;
                    $display("FAIL single_col_hit c=%0d: col_n=%b, required %b", c, col_n,
                             (c < 64) ? 4'b1101 : 4'b1111);
                end
                row_n = 4'b0111;
                #1;
                n_tests++;
                if (col_n !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL single_col_other c=%0d: col_n=%b, required 1111", c, col_n);
                end
                row_n = 4'b1111;
            end
        end
        n_tests++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL single_done_count: got %0d pulses, required 1", n_done);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] keys [6];
        int         c;
        keys[0] = 4'hF; keys[1] = 4'h0; keys[2] = 4'h9;
        keys[3] = 4'h3; keys[4] = 4'h6; keys[5] = 4'h1;
        key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_in = keys[i];
            #1;
            n_tests++;
            if (key_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready push=%0d: key_ready=%b, required 1", i, key_ready);
            end
            @(negedge clk);
        end
        // F popped one edge after its push; the other four fill the queue.
        key_in = keys[5];
        #1;
        n_tests++;
        if (key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: key_ready=%b, required 0", key_ready);
        end
        row_n = row_of(4'hF);
        #1;
        n_tests++;
        if (pressing !== 1'b1 || col_n !== col_of(4'hF)) begin
            n_fail++;
            $display("FAIL b2b_key0: pressing=%b col_n=%b, required 1/%b", pressing, col_n, col_of(4'hF));
        end
        row_n = 4'b1111;
        c = 0;
        while (!key_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (c != 94) begin
            n_fail++;
            $display("FAIL b2b_hold_off: key_ready rose after %0d cycles, required 94", c);
        end
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 1; i < 6; i++) begin
            c = 0;
            while (!pressing && c < 200) begin
                @(negedge clk);
                c++;
            end
            row_n = row_of(keys[i]);
            #1;
            n_tests++;
            if (pressing !== 1'b1 || col_n !== col_of(keys[i])) begin
                n_fail++;
                $display("FAIL b2b_order key=%h: pressing=%b col_n=%b, required 1/%b",
                         keys[i], pressing, col_n, col_of(keys[i]));
            end
            row_n = 4'b1111;
            c = 0;
            while (pressing && c < 200) begin
                @(negedge clk);
                c++;
            end
        end
        wait_idle();
    endtask

    task automatic test_scan();
        int         n_hits;
        logic [3:0] seen;
        logic [3:0] k;
        n_hits = 0;
        seen   = 4'h0;
        push(4'h7);
        @(negedge clk);
        for (int rep = 0; rep < 4; rep++) begin
            for (int r = 0; r < 4; r++) begin
                row_n = ~(4'b0001 << r);
                #1;
                if (col_n !== 4'b1111) begin
                    for (int kk = 0; kk < 16; kk++) begin
                        k = 4'(kk);
                        if (row_of(k) == row_n && col_of(k) == col_n) begin
                            seen = k;
                            n_hits++;
                        end
                    end
                end
                @(negedge clk);
            end
        end
        row_n = 4'b1111;
        n_tests++;
        if (n_hits != 4 || seen !== 4'h7) begin
            n_fail++;
            $display("FAIL scan_decode: hits=%0d key=%h, required 4 hits of key 7", n_hits, seen);
        end
        wait_idle();
    endtask

    task automatic test_multi_row();
        int c;
        push(4'hE);
        @(negedge clk);
        row_n = 4'b0000;
        #1;
        n_tests++;
        if (col_n !== 4'b1011) begin
            n_fail++;
            $display("FAIL multirow_pressed: col_n=%b, required 1011", col_n);
        end
        row_n = 4'b1110;
        #1;
        n_tests++;
        if (col_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL wrong_row: col_n=%b, required 1111", col_n);
        end
        c = 0;
        while (pressing && c < 200) begin
            @(negedge clk);
            c++;
        end
        row_n = 4'b0000;
        #1;
        n_tests++;
        if (pressing !== 1'b0 || col_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL multirow_released: pressing=%b col_n=%b, required 0/1111", pressing, col_n);
        end
        row_n = 4'b1111;
        wait_idle();
    endtask

    task automatic test_reset_mid_press();
        int bad;
        bad = 0;
        push(4'hA);
        push(4'hB);
        repeat (10) @(negedge clk);
        row_n = 4'b1101;
        #1;
        n_tests++;
        if (col_n !== 4'b0111) begin
            n_fail++;
            $display("FAIL rstmid_pre: col_n=%b, required 0111", col_n);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (col_n !== 4'b1111 || pressing !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: col_n=%b pressing=%b busy=%b done=%b, required 1111/0/0/0",
                     col_n, pressing, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (pressing !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        row_n = 4'b1111;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_discard: %0d cycles with activity, required 0", bad);
        end
    endtask

`ifdef KEYPAD_EMU_BOUNCE_EN
    task automatic test_bounce();
        logic [3:0] exp;
        push(4'h2);
        row_n = 4'b1101;
        for (int c = 0; c < 74; c++) begin
            @(negedge clk);
            #1;
            if (c < 8) exp = c[0] ? 4'b1111 : 4'b1011;
            else if (c < 72) exp = 4'b1011;
            else exp = 4'b1111;
            n_tests++;
            if (col_n !== exp) begin
                n_fail++;
                $display("FAIL bounce c=%0d: col_n=%b, required %b", c, col_n, exp);
            end
        end
        row_n = 4'b1111;
        wait_idle();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        key_in    = 4'h0;
        key_valid = 1'b0;
        row_n     = 4'b1111;
        repeat (3) @(negedge clk);
        test_reset();
`ifdef KEYPAD_EMU_BOUNCE_EN
        test_bounce();
`else
        test_single_key();
        test_back_to_back();
        test_scan();
        test_multi_row();
`endif
        test_reset_mid_press();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
